// File: rtl/seg_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : seg_accumulator
// Description : Multi-channel signed accumulator whose ACC_W-bit adder is cut
//               into SEG carry-pipelined segments. Each segment stage owns its
//               slice of every channel's running sum, so back-to-back samples
//               to one channel accumulate with no stall. Lower-segment results
//               ride skew registers so a finished sum leaves aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 26,
    parameter int SEG   = 2,
    parameter int CH    = 4,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [CHW-1:0]          in_ch,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [IN_W-1:0]  A_i,
    output logic                    out_valid,
    output logic [CHW-1:0]          out_ch,
    output logic signed [ACC_W-1:0] out,
    output logic                    out_ovf
);

    localparam int SW  = ACC_W / SEG;
    // Width of the skew register holding all segments below the top one.
    localparam int PRW = (SEG > 1) ? (ACC_W - SW) : 1;
    localparam int TOP = SEG - 1;

    // Pipeline registers feeding stage k (index 0 is the registered input).
    logic             pv_q  [SEG];
    logic [CHW-1:0]   pch_q [SEG];
    logic             pf_q  [SEG];
    logic             pl_q  [SEG];
    logic [ACC_W-1:0] pa_q  [SEG];   // remaining sample bits, shifted down per stage
    logic             c_q   [SEG];   // carry into stage k (always 0 for stage 0)
    logic [PRW-1:0]   pr_q  [SEG];   // already-computed lower segments (skew)

    // Per-channel state: one SW-bit slice per segment plus sticky overflow.
    logic [SW-1:0]    acc_q [CH][SEG];
    logic             ovf_q [CH];

    // Output registers.
    logic             out_valid_q;
    logic [CHW-1:0]   out_ch_q;
    logic [ACC_W-1:0] out_q;
    logic             out_ovf_q;

    // Stage results.
    logic [SW-1:0]    opb_d  [SEG];
    logic [SW-1:0]    sum_d  [SEG];
    logic             cout_d [SEG];
    logic [PRW-1:0]   pr_d   [SEG];
    logic             ovf_now_d;
    logic             ovf_new_d;
    logic [ACC_W-1:0] out_d;
    logic             legal_d;

    // Out-of-range channels only exist when CH is not a power of two.
    if (CH == (1 << CHW)) begin : g_ch_full
        assign legal_d = 1'b1;
    end else begin : g_ch_partial
        assign legal_d = ({1'b0, in_ch} < (CHW + 1)'(CH));
    end

    // Segment adders: sample slice + stored channel slice + carry from below.
    always_comb begin
        ovf_now_d = 1'b0;
        ovf_new_d = 1'b0;
        for (int k = 0; k < SEG; k++) begin
            opb_d[k] = pf_q[k] ? '0 : acc_q[pch_q[k]][k];
            {cout_d[k], sum_d[k]} = {1'b0, pa_q[k][SW-1:0]} + {1'b0, opb_d[k]}
                                  + {{SW{1'b0}}, c_q[k]};
            pr_d[k] = (pr_q[k] >> SW) | (PRW'(sum_d[k]) << (PRW - SW));
        end
        // Signed overflow is judged on the sign bits of the top segment.
        ovf_now_d = (pa_q[TOP][SW-1] == opb_d[TOP][SW-1]) &&
                    (sum_d[TOP][SW-1] != pa_q[TOP][SW-1]);
        ovf_new_d = (~pf_q[TOP] & ovf_q[pch_q[TOP]]) | ovf_now_d;
    end

    if (SEG > 1) begin : g_out_cat
        assign out_d = {sum_d[TOP], pr_q[TOP]};
    end else begin : g_out_one
        assign out_d = sum_d[TOP];
    end

    // Pipeline advance: tags, remaining sample bits, carries and skew.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SEG; k++) begin
                pv_q[k]  <= 1'b0;
                pch_q[k] <= '0;
                pf_q[k]  <= 1'b0;
                pl_q[k]  <= 1'b0;
                pa_q[k]  <= '0;
                c_q[k]   <= 1'b0;
                pr_q[k]  <= '0;
            end
        end else begin
            pv_q[0]  <= in_valid & legal_d;
            pch_q[0] <= in_ch;
            pf_q[0]  <= in_first;
            pl_q[0]  <= in_last;
            pa_q[0]  <= ACC_W'(A_i);
            c_q[0]   <= 1'b0;
            pr_q[0]  <= '0;
            for (int k = 0; k < SEG - 1; k++) begin
                pv_q[k+1]  <= pv_q[k];
                pch_q[k+1] <= pch_q[k];
                pf_q[k+1]  <= pf_q[k];
                pl_q[k+1]  <= pl_q[k];
                pa_q[k+1]  <= pa_q[k] >> SW;
                c_q[k+1]   <= cout_d[k];
                pr_q[k+1]  <= pr_d[k];
            end
        end
    end

    // Channel slices and sticky overflow, written only by valid stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                ovf_q[c] <= 1'b0;
                for (int k = 0; k < SEG; k++) begin
                    acc_q[c][k] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < SEG; k++) begin
                if (pv_q[k]) begin
                    acc_q[pch_q[k]][k] <= sum_d[k];
                end
            end
            if (pv_q[TOP]) begin
                ovf_q[pch_q[TOP]] <= ovf_new_d;
            end
        end
    end

    // Result register: strobes for one cycle and holds its value otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_q       <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= pv_q[TOP] & pl_q[TOP];
            if (pv_q[TOP] & pl_q[TOP]) begin
                out_ch_q  <= pch_q[TOP];
                out_q     <= out_d;
                out_ovf_q <= ovf_new_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out       = out_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_accumulator
// Description : Directed and random stimulus for seg_accumulator, compared
//               against a per-channel arithmetic reference with a timed queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_accumulator;

    localparam int IN_W  = 16;
    localparam int ACC_W = 26;
    localparam int SEG   = 2;
    localparam int CH    = 4;
    localparam int CHW   = 2;
    localparam longint SMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic [CHW-1:0]          in_ch;
    logic                    in_first;
    logic                    in_last;
    logic signed [IN_W-1:0]  A_i;
    logic                    out_valid;
    logic [CHW-1:0]          out_ch;
    logic signed [ACC_W-1:0] out;
    logic                    out_ovf;

    always #5 clk = ~clk;

    seg_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .SEG(SEG), .CH(CH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .A_i(A_i),
        .out_valid(out_valid), .out_ch(out_ch), .out(out), .out_ovf(out_ovf)
    );

    typedef struct {
        int     due;
        int     ch;
        longint val;
        bit     ovf;
    } exp_t;

    exp_t             expq[$];
    longint           msum [CH];
    bit               movf [CH];
    int               edge_n = 0;
    int               nvec = 0;
    int               nerr = 0;
    logic [ACC_W-1:0] held_out;
    logic [CHW-1:0]   held_ch;
    logic             held_ovf;
    logic [ACC_W-1:0] last_out;
    logic [CHW-1:0]   last_ch;
    logic             last_ovf;

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare outputs after an edge against whatever the reference says is due.
    task automatic check_outputs();
        exp_t e;
        if (expq.size() > 0 && expq[0].due == edge_n) begin
            e = expq.pop_front();
            chk("out_valid", ACC_W'(out_valid), ACC_W'(1));
            chk("out", out, e.val[ACC_W-1:0]);
            chk("out_ch", ACC_W'(out_ch), ACC_W'(e.ch));
            chk("out_ovf", ACC_W'(out_ovf), ACC_W'(e.ovf));
            held_out = e.val[ACC_W-1:0];
            held_ch  = CHW'(e.ch);
            held_ovf = e.ovf;
            last_out = out;
            last_ch  = out_ch;
            last_ovf = out_ovf;
        end else begin
            chk("idle_valid", ACC_W'(out_valid), ACC_W'(0));
            chk("held_out", out, held_out);
            chk("held_ch", ACC_W'(out_ch), ACC_W'(held_ch));
            chk("held_ovf", ACC_W'(out_ovf), ACC_W'(held_ovf));
        end
    endtask

    // Reference: plain signed arithmetic with wrap and range-based overflow.
    task automatic model_accept();
        int     c;
        longint s;
        bit     of;
        if (reset_n && in_valid && int'(in_ch) < CH) begin
            c = int'(in_ch);
            if (in_first) begin
                msum[c] = 0;
                movf[c] = 1'b0;
            end
            s  = msum[c] + longint'(A_i);
            of = (s > SMAX) || (s < SMIN);
            s  = s & ((64'sd1 <<< ACC_W) - 1);
            if (s > SMAX) s = s - (64'sd1 <<< ACC_W);
            msum[c] = s;
            movf[c] = movf[c] | of;
            if (in_last) expq.push_back('{edge_n + SEG, c, s, movf[c]});
        end
    endtask

    task automatic step(input bit v, input int c, input bit f, input bit l, input int a);
        in_valid = v;
        in_ch    = CHW'(c);
        in_first = f;
        in_last  = l;
        A_i      = IN_W'(a);
        @(posedge clk);
        edge_n++;
        #1;
        check_outputs();
        model_accept();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic expect_last(input string tag, input logic [ACC_W-1:0] val,
                               input int c, input bit ovf);
        chk({tag, "_out"}, last_out, val);
        chk({tag, "_ch"}, ACC_W'(last_ch), ACC_W'(c));
        chk({tag, "_ovf"}, ACC_W'(last_ovf), ACC_W'(ovf));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_ch    = '0;
        A_i      = '0;
        #1;
        expq.delete();
        for (int c = 0; c < CH; c++) begin
            msum[c] = 0;
            movf[c] = 1'b0;
        end
        held_out = '0;
        held_ch  = '0;
        held_ovf = 1'b0;
        chk("rst_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("rst_out", out, '0);
        chk("rst_ch", ACC_W'(out_ch), ACC_W'(0));
        chk("rst_ovf", ACC_W'(out_ovf), ACC_W'(0));
        idle(3);
        reset_n = 1'b1;
    endtask

    initial begin
        last_out = '0;
        last_ch  = '0;
        last_ovf = 1'b0;
        #1;
        do_reset();
        idle(2);

        // Three back-to-back samples on ch0.
        step(1, 0, 1, 0, 1000);
        step(1, 0, 0, 0, 2000);
        step(1, 0, 0, 1, 3000);
        idle(3);
        expect_last("sum6000", 26'd6000, 0, 1'b0);

        // Carry from the low segment into bit 13.
        step(1, 1, 1, 0, 8191);
        step(1, 1, 0, 1, 1);
        idle(3);
        expect_last("carry", 26'd8192, 1, 1'b0);

        // Negative accumulation.
        step(1, 2, 1, 0, -5);
        step(1, 2, 0, 0, -7);
        step(1, 2, 0, 1, 3);
        idle(3);
        expect_last("neg", 26'h3FFFFF7, 2, 1'b0);

        // Interleaved channels; the queue enforces issue order (400 then -200).
        for (int i = 0; i < 4; i++) begin
            step(1, 0, i == 0, i == 3, 100);
            step(1, 3, i == 0, i == 3, -50);
        end
        idle(3);
        expect_last("ilv", 26'h3FFFF38, 3, 1'b0);

        // Overflow: 1025 x 32767 = 33586175 wraps negative, sticky flag set.
        for (int i = 0; i < 1025; i++) step(1, 1, i == 0, i == 1024, 32767);
        idle(3);
        expect_last("ovf", 26'd33586175, 1, 1'b1);
        step(1, 1, 1, 1, 5);
        idle(3);
        expect_last("ovfclr", 26'd5, 1, 1'b0);

        // Single-sample result (first and last together).
        step(1, 2, 1, 1, -1234);
        idle(3);
        expect_last("single", 26'h3FFFB2E, 2, 1'b0);

        // Reset while a last sample is in flight: it must vanish.
        step(1, 0, 1, 1, 123);
        do_reset();
        idle(3);
        step(1, 0, 0, 1, 7);
        idle(3);
        expect_last("postrst", 26'd7, 0, 1'b0);

        // Random traffic on all channels.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, int'($urandom % CH), ($urandom % 5) == 0,
                 ($urandom % 4) == 0,
                 (($urandom % 3) == 0) ? 32767 - int'($urandom % 8) : int'($urandom));
        end
        idle(4);
        chk("drained", ACC_W'(expq.size()), ACC_W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
